// File: rtl/verify_sequencer_pkg.sv
// Shared types, defaults and helpers for the verification run sequencer.
package verify_sequencer_pkg;

    // Run-controller states, 3-bit encoded.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StChipRst = 3'd1,
        StBase    = 3'd2,
        StRun     = 3'd3,
        StDrain   = 3'd4,
        StDone    = 3'd5
    } seq_state_e;

    // Default timing, in platform clock cycles.
    localparam int unsigned DEF_RST_HOLD       = 1000;
    localparam int unsigned DEF_DRAIN_CYCLES   = 5000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 2_000_000;

    localparam int unsigned CNT_W = 32;

    // Modular distance between a free-running counter and its snapshot.
    // Wrap of the counter between snapshot and now is harmless.
    function automatic logic [CNT_W-1:0] delta32(input logic [CNT_W-1:0] now,
                                                 input logic [CNT_W-1:0] base);
        return now - base;
    endfunction

endpackage

// File: rtl/verify_sequencer_stall.sv
// Stall timer: watches a counter for changes and counts consecutive unchanged
// cycles, saturating at all-ones. Exposes drain and timeout threshold hits.
module stall_timer
    import verify_sequencer_pkg::*;
#(
    parameter int unsigned DRAIN_N   = DEF_DRAIN_CYCLES,
    parameter int unsigned TIMEOUT_N = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] value,
    output logic             drain_hit,
    output logic             timeout_hit
);

    localparam logic [CNT_W-1:0] DRAIN_LIMIT   = CNT_W'(DRAIN_N);
    // Compare against N-1 so the decision edge lands exactly N cycles after
    // the counter was last cleared.
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_N - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX     = {CNT_W{1'b1}};

    logic [CNT_W-1:0] prev_q;
    logic [CNT_W-1:0] count_q;
    logic             changed;

    assign changed     = (value != prev_q);
    assign drain_hit   = !changed && (count_q >= DRAIN_LIMIT);
    assign timeout_hit = !changed && (count_q >= TIMEOUT_LIMIT);

    // Track the previous value and the saturating run of unchanged cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            count_q <= '0;
        end else begin
            prev_q <= value;
            if (clr || changed) begin
                count_q <= '0;
            end else if (count_q != COUNT_MAX) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/verify_sequencer.sv
// Run controller: chip reset, baseline snapshot, generator enable until the
// target count is answered, drain of in-flight results, then a latched verdict.
module verify_sequencer
    import verify_sequencer_pkg::*;
#(
    parameter int unsigned RST_HOLD       = DEF_RST_HOLD,
    parameter int unsigned DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] total,
    input  logic [CNT_W-1:0] correct,
    output logic             work,
    output logic             chip_rst_req,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] run_total,
    output logic [CNT_W-1:0] run_errors
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    seq_state_e       state_q;
    seq_state_e       next_state;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] base_t_q;
    logic [CNT_W-1:0] base_c_q;
    logic [CNT_W-1:0] hold_cnt_q;

    logic [CNT_W-1:0] dt;
    logic [CNT_W-1:0] dc;
    logic [CNT_W-1:0] err;
    logic             target_hit;
    logic             state_chg;
    logic             drain_hit;
    logic             timeout_hit;

    assign dt         = delta32(total, base_t_q);
    assign dc         = delta32(correct, base_c_q);
    assign err        = dt - dc;
    assign target_hit = (dt >= target_q);
    // Any transition restarts the stall window for the new state.
    assign state_chg  = (next_state != state_q);

    stall_timer #(
        .DRAIN_N   (DRAIN_CYCLES),
        .TIMEOUT_N (TIMEOUT_CYCLES)
    ) u_stall (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (state_chg),
        .value       (total),
        .drain_hit   (drain_hit),
        .timeout_hit (timeout_hit)
    );

    // Next-state decision; abort beats everything, including a same-cycle start.
    always_comb begin
        next_state = state_q;
        if (abort) begin
            next_state = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) next_state = StChipRst;
                end
                StChipRst: begin
                    if (hold_cnt_q == HOLD_LAST) next_state = StBase;
                end
                StBase: begin
                    next_state = (target_q == '0) ? StDone : StRun;
                end
                StRun: begin
                    // Reaching the target wins over a coincident stall expiry.
                    if (target_hit)       next_state = StDrain;
                    else if (timeout_hit) next_state = StDone;
                end
                StDrain: begin
                    if (drain_hit) next_state = StDone;
                end
                default: next_state = StIdle;
            endcase
        end
    end

    // State register with registered outputs, snapshots and verdict latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            target_q     <= '0;
            base_t_q     <= '0;
            base_c_q     <= '0;
            hold_cnt_q   <= '0;
            work         <= 1'b0;
            chip_rst_req <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            run_total    <= '0;
            run_errors   <= '0;
        end else begin
            state_q      <= next_state;
            work         <= (next_state == StRun);
            chip_rst_req <= (next_state == StChipRst);
            busy         <= !((next_state == StIdle) || (next_state == StDone));
            done         <= (next_state == StDone);

            if ((state_q == StChipRst) && (next_state == StChipRst)) begin
                hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            end else begin
                hold_cnt_q <= '0;
            end

            if (state_q == StBase) begin
                base_t_q <= total;
                base_c_q <= correct;
            end

            if ((next_state == StChipRst) && (state_q != StChipRst)) begin
                target_q   <= target;
                pass       <= 1'b0;
                timeout    <= 1'b0;
                run_total  <= '0;
                run_errors <= '0;
            end else if (next_state == StIdle) begin
                pass       <= 1'b0;
                timeout    <= 1'b0;
                run_total  <= '0;
                run_errors <= '0;
            end else if ((next_state == StDone) && (state_q != StDone)) begin
                if (state_q == StBase) begin
                    // Zero-length run: trivially passes, snapshot not yet valid.
                    pass       <= 1'b1;
                    timeout    <= 1'b0;
                    run_total  <= '0;
                    run_errors <= '0;
                end else begin
                    // From RUN the only way to DONE is a stall expiry.
                    timeout    <= (state_q == StRun);
                    run_total  <= dt;
                    run_errors <= err;
                    pass       <= (err == '0) && target_hit && (state_q != StRun);
                end
            end
        end
    end

endmodule
